// File: rtl/vp_recovery_controller.sv
`default_nettype none
// ============================================================================
// Module   : vp_recovery_controller
// Purpose  : Checkpoint / rollback sequencer for load value prediction.
//            A predicted load snapshots the register file on issue. The
//            controller then waits for the real D-cache data. A match retires
//            the speculation. A mismatch (or a watchdog expiry) drives a
//            register restore, a pipeline-wide flush and a PC redirect,
//            followed by a non-speculative replay of the load.
// Ports    : clk, rst                   - clock, synchronous active-high reset
//            lw_issue_valid/_pc         - predicted load leaving decode
//            pred_value                 - value predicted for that load
//            hc_stall                   - decode stall; blocks issue in IDLE
//            mem_load_valid/_data       - real data for the outstanding load
//            take_snapshot              - snapshot strobe (issue cycle)
//            recover_snapshot           - restore strobe (first RECOVER cycle)
//            flush_all                  - flush all pipeline registers
//            redirect_we, redirect_pc   - PC overload request
//            stall_issue                - hold further predicted loads
//            vp_suppress                - predictor disabled during replay
//            correct_prediction         - outcome pulse, match
//            mispredict                 - outcome pulse, mismatch / timeout
// Config   : VP_TIMEOUT_EN - when defined, a watchdog forces recovery after
//            TIMEOUT_CYCLES speculative cycles without returned data.
// Revision : 1.0 - initial release
// ============================================================================
module vp_recovery_controller #(
    parameter int DATA_WIDTH     = 32,
    parameter int RECOVER_CYCLES = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lw_issue_valid,
    input  logic [DATA_WIDTH-1:0] lw_issue_pc,
    input  logic [DATA_WIDTH-1:0] pred_value,
    input  logic                  hc_stall,
    input  logic                  mem_load_valid,
    input  logic [DATA_WIDTH-1:0] mem_load_data,
    output logic                  take_snapshot,
    output logic                  recover_snapshot,
    output logic                  flush_all,
    output logic                  redirect_we,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  stall_issue,
    output logic                  vp_suppress,
    output logic                  correct_prediction,
    output logic                  mispredict
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SPEC    = 2'd1;
    localparam logic [1:0] S_RECOVER = 2'd2;
    localparam logic [1:0] S_REPLAY  = 2'd3;

    // Recovery counter runs 0 .. RECOVER_CYCLES-1 while in RECOVER.
    localparam int              C_RC_W    = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
    localparam logic [C_RC_W-1:0] C_RC_LAST = C_RC_W'(RECOVER_CYCLES - 1);

    // Reject configurations the sequencing cannot honour.
    generate
        if (RECOVER_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
            $error("vp_recovery_controller: RECOVER_CYCLES must be >= 1 and TIMEOUT_CYCLES >= 2");
        end
    endgenerate

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [DATA_WIDTH-1:0] r_spec_pc;
    logic [DATA_WIDTH-1:0] r_spec_val;
    logic [C_RC_W-1:0]     r_rc_cnt;
    logic                  w_latch;
    logic                  w_timeout;

`ifdef VP_TIMEOUT_EN
    localparam int              C_WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [C_WD_W-1:0] C_WD_LAST = C_WD_W'(TIMEOUT_CYCLES - 1);

    logic [C_WD_W-1:0] r_wd_cnt;

    // Expiry is flagged in the cycle that would be the TIMEOUT_CYCLES-th empty
    // SPEC cycle; the counter never wraps because expiry leaves SPEC.
    assign w_timeout = (r_state == S_SPEC) && !mem_load_valid && (r_wd_cnt == C_WD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd_cnt <= '0;
        end else if (w_latch) begin
            r_wd_cnt <= '0;
        end else if ((r_state == S_SPEC) && !mem_load_valid) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    assign redirect_pc = r_spec_pc;

    always_comb begin
        w_next_state       = r_state;
        w_latch            = 1'b0;
        take_snapshot      = 1'b0;
        recover_snapshot   = 1'b0;
        flush_all          = 1'b0;
        redirect_we        = 1'b0;
        stall_issue        = 1'b0;
        vp_suppress        = 1'b0;
        correct_prediction = 1'b0;
        mispredict         = 1'b0;
        case (r_state)
            S_IDLE: begin
                // mem_load_valid here belongs to an older load and is ignored.
                if (lw_issue_valid && !hc_stall) begin
                    take_snapshot = 1'b1;
                    w_latch       = 1'b1;
                    w_next_state  = S_SPEC;
                end
            end
            S_SPEC: begin
                stall_issue = 1'b1;
                if (mem_load_valid) begin
                    if (mem_load_data == r_spec_val) begin
                        correct_prediction = 1'b1;
                        w_next_state       = S_IDLE;
                    end else begin
                        mispredict   = 1'b1;
                        w_next_state = S_RECOVER;
                    end
                end else if (w_timeout) begin
                    mispredict   = 1'b1;
                    w_next_state = S_RECOVER;
                end
            end
            S_RECOVER: begin
                flush_all   = 1'b1;
                stall_issue = 1'b1;
                if (r_rc_cnt == '0) begin
                    recover_snapshot = 1'b1;
                    redirect_we      = 1'b1;
                end
                if (r_rc_cnt == C_RC_LAST) begin
                    w_next_state = S_REPLAY;
                end
            end
            S_REPLAY: begin
                vp_suppress = 1'b1;
                if (mem_load_valid) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_spec_pc  <= '0;
            r_spec_val <= '0;
            r_rc_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_latch) begin
                r_spec_pc  <= lw_issue_pc;
                r_spec_val <= pred_value;
            end
            // Counts only while remaining in RECOVER; zero on entry.
            if ((r_state == S_RECOVER) && (w_next_state == S_RECOVER)) begin
                r_rc_cnt <= r_rc_cnt + 1'b1;
            end else begin
                r_rc_cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vp_recovery_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_vp_recovery_controller
// Purpose  : Self-checking bench for vp_recovery_controller. Expected load
//            outcomes are queued at issue time and popped when the DUT pulses
//            correct_prediction / mispredict; cycle-level sequencing is
//            checked directly against hand-derived values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vp_recovery_controller;

    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          lw_issue_valid;
    logic [DW-1:0] lw_issue_pc;
    logic [DW-1:0] pred_value;
    logic          hc_stall;
    logic          mem_load_valid;
    logic [DW-1:0] mem_load_data;
    logic          take_snapshot;
    logic          recover_snapshot;
    logic          flush_all;
    logic          redirect_we;
    logic [DW-1:0] redirect_pc;
    logic          stall_issue;
    logic          vp_suppress;
    logic          correct_prediction;
    logic          mispredict;

    vp_recovery_controller #(
        .DATA_WIDTH     (DW),
        .RECOVER_CYCLES (2),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .lw_issue_valid     (lw_issue_valid),
        .lw_issue_pc        (lw_issue_pc),
        .pred_value         (pred_value),
        .hc_stall           (hc_stall),
        .mem_load_valid     (mem_load_valid),
        .mem_load_data      (mem_load_data),
        .take_snapshot      (take_snapshot),
        .recover_snapshot   (recover_snapshot),
        .flush_all          (flush_all),
        .redirect_we        (redirect_we),
        .redirect_pc        (redirect_pc),
        .stall_issue        (stall_issue),
        .vp_suppress        (vp_suppress),
        .correct_prediction (correct_prediction),
        .mispredict         (mispredict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          mis;
        logic [DW-1:0] pc;
    } exp_t;

    exp_t sb[$];
    int   n_chk;
    int   n_fail;
    int   n_snap;
    int   n_rec;
    int   n_flush;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [DW-1:0] pc, input logic [DW-1:0] pv,
                         input logic st, input logic mv, input logic [DW-1:0] md);
        lw_issue_valid = iv;
        lw_issue_pc    = pc;
        pred_value     = pv;
        hc_stall       = st;
        mem_load_valid = mv;
        mem_load_data  = md;
    endtask

    task automatic clr_counts();
        n_snap  = 0;
        n_rec   = 0;
        n_flush = 0;
    endtask

    // Monitor at the falling edge, then advance to just after the next rise.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (!rst) begin
            if (take_snapshot)    n_snap++;
            if (recover_snapshot) n_rec++;
            if (flush_all)        n_flush++;
            if (correct_prediction || mispredict) begin
                if (sb.size() == 0) begin
                    chk("unexpected_outcome", {correct_prediction, mispredict}, 2'b00);
                end else begin
                    e = sb.pop_front();
                    chk("outcome_kind", {correct_prediction, mispredict}, e.mis ? 2'b01 : 2'b10);
                    chk("outcome_pc", redirect_pc, e.pc);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        clr_counts();
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reset_outs", {take_snapshot, recover_snapshot, flush_all, redirect_we, stall_issue,
                           vp_suppress, correct_prediction, mispredict}, 8'h00);
        chk("reset_redirect_pc", redirect_pc, 32'h0);

        // Correct prediction: data returns 3 cycles after issue.
        clr_counts();
        drive(1'b1, 32'h0040_0100, 32'h5, 1'b0, 1'b0, '0);
        sb.push_back('{mis: 1'b0, pc: 32'h0040_0100});
        #1;
        chk("c_snap", take_snapshot, 1'b1);
        chk("c_idle_nostall", stall_issue, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
        #1;
        chk("c_spec_stall", stall_issue, 1'b1);
        chk("c_snap_once", take_snapshot, 1'b0);
        tick();
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b1, 32'h5);
        #1;
        chk("c_correct", correct_prediction, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
        #1;
        chk("c_back_idle", {stall_issue, vp_suppress, flush_all}, 3'b000);
        chk("c_no_flush", n_flush, 0);
        chk("c_no_recover", n_rec, 0);
        chk("c_snap_count", n_snap, 1);

        // Misprediction; stale mem_load_valid in the issue cycle is ignored.
        clr_counts();
        drive(1'b1, 32'h0040_0200, 32'h5, 1'b0, 1'b1, 32'h6);
        sb.push_back('{mis: 1'b1, pc: 32'h0040_0200});
        #1;
        chk("m_snap", take_snapshot, 1'b1);
        chk("m_stale_ignored", {correct_prediction, mispredict}, 2'b00);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
        #1;
        chk("m_spec_wait", {correct_prediction, mispredict}, 2'b00);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b1, 32'h6);
        #1;
        chk("m_mispredict", mispredict, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
        #1;
        chk("m_rec_first", {recover_snapshot, redirect_we, flush_all, stall_issue}, 4'b1111);
        chk("m_redirect_pc", redirect_pc, 32'h0040_0200);
        tick();
        chk("m_rec_second", {recover_snapshot, redirect_we, flush_all, stall_issue}, 4'b0011);
        tick();
        chk("m_replay", {flush_all, vp_suppress, stall_issue}, 3'b010);
        tick();
        chk("m_replay_hold", vp_suppress, 1'b1);
        drive(1'b0, '0, '0, 1'b0, 1'b1, 32'h123);
        #1;
        chk("m_replay_nopulse", {correct_prediction, mispredict, vp_suppress}, 3'b001);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
        #1;
        chk("m_idle", {vp_suppress, stall_issue, flush_all}, 3'b000);
        chk("m_flush_cycles", n_flush, 2);
        chk("m_rec_count", n_rec, 1);

        // Back-to-back issue while speculating.
        clr_counts();
        drive(1'b1, 32'h0040_0300, 32'h7, 1'b0, 1'b0, '0);
        sb.push_back('{mis: 1'b0, pc: 32'h0040_0300});
        tick();
        drive(1'b1, 32'h0000_0999, 32'h1, 1'b0, 1'b0, '0);
        #1;
        chk("b_no_snap", take_snapshot, 1'b0);
        chk("b_stall", stall_issue, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b1, 32'h7);
        #1;
        chk("b_pc_kept", redirect_pc, 32'h0040_0300);
        chk("b_correct", correct_prediction, 1'b1);
        tick();
        chk("b_snap_count", n_snap, 1);

        // Stalled issue is dropped.
        drive(1'b1, 32'h0040_0abc, 32'h3, 1'b1, 1'b0, '0);
        #1;
        chk("s_no_snap", take_snapshot, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
        #1;
        chk("s_idle", stall_issue, 1'b0);
        chk("s_pc_kept", redirect_pc, 32'h0040_0300);

        // Watchdog.
        drive(1'b1, 32'h0040_0400, 32'h9, 1'b0, 1'b0, '0);
`ifdef VP_TIMEOUT_EN
        sb.push_back('{mis: 1'b1, pc: 32'h0040_0400});
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("w_wait", mispredict, 1'b0);
            tick();
        end
        #1;
        chk("w_timeout", mispredict, 1'b1);
        tick();
        chk("w_rec", {recover_snapshot, redirect_we, flush_all}, 3'b111);
        chk("w_redirect_pc", redirect_pc, 32'h0040_0400);
        tick();
        tick();
        chk("w_replay", vp_suppress, 1'b1);
        drive(1'b0, '0, '0, 1'b0, 1'b1, '0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
        #1;
        chk("w_idle", {vp_suppress, stall_issue}, 2'b00);
`else
        sb.push_back('{mis: 1'b0, pc: 32'h0040_0400});
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
        begin
            int n_spec;
            n_spec = 0;
            for (int i = 0; i < 100; i++) begin
                #1;
                if (stall_issue && !flush_all && !vp_suppress && !mispredict) n_spec++;
                tick();
            end
            chk("w_still_spec", n_spec, 100);
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1, 32'h9);
        #1;
        chk("w_late_correct", correct_prediction, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
`endif

        // Reset in the first RECOVER cycle.
        drive(1'b1, 32'h0040_0500, 32'h1, 1'b0, 1'b0, '0);
        sb.push_back('{mis: 1'b1, pc: 32'h0040_0500});
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b1, 32'h2);
        #1;
        chk("r_mispredict", mispredict, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
        rst = 1'b1;
        #1;
        chk("r_first_rec", recover_snapshot, 1'b1);
        tick();
        rst = 1'b0;
        #1;
        chk("r_outs_zero", {take_snapshot, recover_snapshot, flush_all, redirect_we, stall_issue,
                            vp_suppress, correct_prediction, mispredict}, 8'h00);
        chk("r_pc_zero", redirect_pc, 32'h0);
        tick();
        chk("r_stay_idle", {flush_all, recover_snapshot, stall_issue}, 3'b000);

        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
